tl_inflight_monitor: RTL and testbench

Parametrised TileLink-UL/UH protocol monitor for one A/D channel pair. It tracks in-flight requests per source ID, counts burst beats on both channels, and checks handshake stability, response matching and forward progress. Unlike the pure assertion monitors, it reports violations on registered output ports, so it can be synthesised into the FPGA build as well as bound into simulation. One instance is placed on each TileLink edge under test.

---
 rtl/tl_inflight_monitor.sv | 190 +++++++++++++++++++
 tb/tb_tl_inflight_monitor.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/tl_inflight_monitor.sv
// TileLink-UL/UH in-flight monitor for one A/D channel pair: tracks outstanding
// sources and burst beats, and reports protocol violations on registered ports.
module tl_inflight_monitor #(
  parameter int ADDR_W    = 32,
  parameter int SRC_W     = 8,
  parameter int BEAT_LOG2 = 3,
  parameter int TIMEOUT   = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              a_valid,
  input  logic              a_ready,
  input  logic [2:0]        a_opcode,
  input  logic [2:0]        a_param,
  input  logic [2:0]        a_size,
  input  logic [SRC_W-1:0]  a_source,
  input  logic [ADDR_W-1:0] a_address,
  input  logic              d_valid,
  input  logic              d_ready,
  input  logic [2:0]        d_opcode,
  input  logic [2:0]        d_size,
  input  logic [SRC_W-1:0]  d_source,
  input  logic              d_denied,
  input  logic              d_corrupt,
  output logic              err_pulse,
  output logic [3:0]        err_code,
  output logic [3:0]        first_err,
  output logic [SRC_W:0]    inflight_count
);

  localparam int NSRC = 1 << SRC_W;
  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [3:0] {
    ERR_NONE       = 4'd0,
    ERR_A_OPCODE   = 4'd1,
    ERR_A_ALIGN    = 4'd2,
    ERR_A_SRC_BUSY = 4'd3,
    ERR_A_UNSTABLE = 4'd4,
    ERR_A_BURST    = 4'd5,
    ERR_D_NO_REQ   = 4'd6,
    ERR_D_OPCODE   = 4'd7,
    ERR_D_SIZE     = 4'd8,
    ERR_D_UNSTABLE = 4'd9,
    ERR_TIMEOUT    = 4'd10
  } err_e;

  typedef struct packed {
    logic [2:0]       opcode;
    logic [2:0]       param;
    logic [2:0]       size;
    logic [SRC_W-1:0] source;
  } a_hdr_t;

  typedef struct packed {
    logic [2:0]       opcode;
    logic [2:0]       size;
    logic [SRC_W-1:0] source;
    logic             denied;
    logic             corrupt;
  } d_hdr_t;

  function automatic logic [7:0] beats_of(input logic data, input logic [2:0] size);
    if (data && (int'(size) > BEAT_LOG2)) return 8'(1 << (int'(size) - BEAT_LOG2));
    return 8'd1;
  endfunction

  // Returns {check_enable, required D opcode}; opcodes 6/7 have no legal response.
  function automatic logic [3:0] d_op_for(input logic [2:0] a_op);
    case (a_op)
      3'd0, 3'd1:       return 4'b1_000;
      3'd2, 3'd3, 3'd4: return 4'b1_001;
      3'd5:             return 4'b1_010;
      default:          return 4'b0_000;
    endcase
  endfunction

  logic              a_fire, d_fire, a_first, d_first, d_last, d_clr_hit;
  logic [7:0]        a_cnt, d_cnt, a_beats, d_beats;
  a_hdr_t            a_cur, a_hdr, a_prev;
  d_hdr_t            d_cur, d_prev;
  logic [ADDR_W-1:0] a_prev_addr, a_mask;
  logic              a_hold, d_hold;
  logic [NSRC-1:0]   inflight;
  logic [5:0]        tbl [NSRC];
  logic [5:0]        d_entry;
  logic [3:0]        d_req;
  logic [WD_W-1:0]   wd;
  logic              wd_run, wd_flag, cnt_inc, cnt_dec;
  logic [10:1]       viol;
  logic [3:0]        code;

  assign a_fire    = a_valid && a_ready;
  assign d_fire    = d_valid && d_ready;
  assign a_first   = (a_cnt == 8'd0);
  assign d_first   = (d_cnt == 8'd0);
  assign a_beats   = beats_of(!a_opcode[2], a_size);
  assign d_beats   = beats_of(d_opcode == 3'd1, d_size);
  assign d_last    = d_first ? (d_beats == 8'd1) : (d_cnt == 8'd1);
  assign d_clr_hit = d_fire && d_last;
  assign a_cur     = '{opcode: a_opcode, param: a_param, size: a_size, source: a_source};
  assign d_cur     = '{opcode: d_opcode, size: d_size, source: d_source,
                       denied: d_denied, corrupt: d_corrupt};
  assign a_mask    = ~({ADDR_W{1'b1}} << a_size);
  assign d_entry   = tbl[d_source];
  assign d_req     = d_op_for(d_entry[5:3]);

  assign wd_run  = (inflight_count != '0) && !d_fire;
  assign wd_flag = (TIMEOUT != 0) && wd_run && (wd == WD_W'(TIMEOUT - 1));

  // A set and a clear on the same source cancel out; only a genuinely new or
  // genuinely retired entry moves the count.
  assign cnt_inc = a_fire && a_first && !inflight[a_source];
  assign cnt_dec = d_clr_hit && inflight[d_source] &&
                   !(a_fire && a_first && (a_source == d_source));

  always_comb begin
    viol                 = '0;
    viol[ERR_A_OPCODE]   = a_fire && (a_opcode[2:1] == 2'b11);
    viol[ERR_A_ALIGN]    = a_fire && a_first && |(a_address & a_mask);
    viol[ERR_A_SRC_BUSY] = a_fire && a_first && inflight[a_source] &&
                           !(d_clr_hit && (d_source == a_source));
    viol[ERR_A_UNSTABLE] = a_hold && (!a_valid || (a_cur != a_prev) || (a_address != a_prev_addr));
    viol[ERR_A_BURST]    = a_fire && !a_first && (a_cur != a_hdr);
    viol[ERR_D_NO_REQ]   = d_fire && d_first && !inflight[d_source];
    viol[ERR_D_OPCODE]   = d_fire && d_first && inflight[d_source] && d_req[3] &&
                           (d_opcode != d_req[2:0]);
    viol[ERR_D_SIZE]     = d_fire && d_first && inflight[d_source] && (d_size != d_entry[2:0]);
    viol[ERR_D_UNSTABLE] = d_hold && (!d_valid || (d_cur != d_prev));
    viol[ERR_TIMEOUT]    = wd_flag;
  end

  always_comb begin
    code = ERR_NONE;
    for (int i = 10; i >= 1; i--) begin
      if (viol[i]) code = 4'(i);
    end
  end

  // NOTE: the request table is a plain memory with no reset; every entry is
  // written before it can be read for a live source, so clearing it buys nothing.
  always_ff @(posedge clock) begin
    if (a_fire && a_first) tbl[a_source] <= {a_opcode, a_size};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      a_cnt          <= '0;
      d_cnt          <= '0;
      a_hdr          <= '0;
      a_prev         <= '0;
      a_prev_addr    <= '0;
      d_prev         <= '0;
      a_hold         <= 1'b0;
      d_hold         <= 1'b0;
      inflight       <= '0;
      inflight_count <= '0;
      wd             <= '0;
      err_pulse      <= 1'b0;
      err_code       <= '0;
      first_err      <= '0;
    end else begin
      if (a_fire) a_cnt <= a_first ? a_beats - 8'd1 : a_cnt - 8'd1;
      if (d_fire) d_cnt <= d_first ? d_beats - 8'd1 : d_cnt - 8'd1;
      if (a_fire && a_first) a_hdr <= a_cur;

      a_hold      <= a_valid && !a_ready;
      d_hold      <= d_valid && !d_ready;
      a_prev      <= a_cur;
      a_prev_addr <= a_address;
      d_prev      <= d_cur;

      // NOTE: both updates are non-blocking, so the later set wins over the
      // earlier clear when A and D hit the same source in one cycle.
      if (d_clr_hit)         inflight[d_source] <= 1'b0;
      if (a_fire && a_first) inflight[a_source] <= 1'b1;

      if (cnt_inc && !cnt_dec)      inflight_count <= inflight_count + 1'b1;
      else if (cnt_dec && !cnt_inc) inflight_count <= inflight_count - 1'b1;

      if (!wd_run)                      wd <= '0;
      else if (wd != WD_W'(TIMEOUT))    wd <= wd + 1'b1;

      err_pulse <= |viol;
      err_code  <= code;
      if ((first_err == 4'd0) && |viol) first_err <= code;
    end
  end

endmodule

// File: tb/tb_tl_inflight_monitor.sv
// Scoreboard bench for tl_inflight_monitor: each clocked stimulus cycle queues the
// error code it should produce, and a negedge monitor compares the registered outputs.
module tb_tl_inflight_monitor;

  localparam int ADDR_W    = 32;
  localparam int SRC_W     = 4;
  localparam int BEAT_LOG2 = 3;
  localparam int TIMEOUT   = 16;

  logic              clock = 1'b0;
  logic              reset;
  logic              a_valid, a_ready, d_valid, d_ready, d_denied, d_corrupt;
  logic [2:0]        a_opcode, a_param, a_size, d_opcode, d_size;
  logic [SRC_W-1:0]  a_source, d_source;
  logic [ADDR_W-1:0] a_address;
  logic              err_pulse;
  logic [3:0]        err_code, first_err;
  logic [SRC_W:0]    inflight_count;

  always #5 clock = ~clock;

  tl_inflight_monitor #(
    .ADDR_W(ADDR_W), .SRC_W(SRC_W), .BEAT_LOG2(BEAT_LOG2), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
    .a_size(a_size), .a_source(a_source), .a_address(a_address),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_size(d_size),
    .d_source(d_source), .d_denied(d_denied), .d_corrupt(d_corrupt),
    .err_pulse(err_pulse), .err_code(err_code), .first_err(first_err),
    .inflight_count(inflight_count)
  );

  typedef struct {
    string tag;
    int    code;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check({mon_e.tag, " pulse"}, int'(err_pulse), int'(mon_e.code != 0));
      check({mon_e.tag, " code"}, int'(err_code), mon_e.code);
    end
  end

  task automatic idle();
    a_valid = 1'b0; a_ready = 1'b0; a_opcode = '0; a_param = '0; a_size = '0;
    a_source = '0; a_address = '0;
    d_valid = 1'b0; d_ready = 1'b0; d_opcode = '0; d_size = '0; d_source = '0;
    d_denied = 1'b0; d_corrupt = 1'b0;
  endtask

  task automatic a_req(input logic [2:0] op, input logic [2:0] prm, input logic [2:0] sz,
                       input logic [SRC_W-1:0] src, input logic [ADDR_W-1:0] addr,
                       input logic rdy = 1'b1);
    a_valid = 1'b1; a_ready = rdy; a_opcode = op; a_param = prm; a_size = sz;
    a_source = src; a_address = addr;
  endtask

  task automatic d_rsp(input logic [2:0] op, input logic [2:0] sz,
                       input logic [SRC_W-1:0] src, input logic rdy = 1'b1,
                       input logic den = 1'b0);
    d_valid = 1'b1; d_ready = rdy; d_opcode = op; d_size = sz; d_source = src;
    d_denied = den; d_corrupt = 1'b0;
  endtask

  // Clocks the inputs set up by the caller and queues the code they should raise.
  task automatic step(input string tag, input int exp);
    exp_t e;
    @(posedge clock);
    e.tag  = tag;
    e.code = exp;
    exp_q.push_back(e);
    @(negedge clock);
    idle();
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    idle();
    @(posedge clock);
    @(negedge clock);
    check({tag, " err_pulse"}, int'(err_pulse), 0);
    check({tag, " err_code"}, int'(err_code), 0);
    check({tag, " first_err"}, int'(first_err), 0);
    check({tag, " count"}, int'(inflight_count), 0);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    repeat (2) @(negedge clock);
    do_reset("rst0");

    // Single-beat Get with AccessAckData five cycles later.
    a_req(3'd4, 3'd0, 3'd3, 4'd3, 32'h100);
    step("get3", 0);
    check("get3 count t1", int'(inflight_count), 1);
    for (int k = 2; k <= 5; k++) begin
      step("get3 idle", 0);
      check($sformatf("get3 count t%0d", k), int'(inflight_count), 1);
    end
    d_rsp(3'd1, 3'd3, 4'd3);
    step("get3 ack", 0);
    check("get3 count t6", int'(inflight_count), 0);

    // Four-beat PutFull, clean and then with a source change on beat 3.
    for (int b = 0; b < 4; b++) begin
      a_req(3'd0, 3'd0, 3'd5, 4'd1, 32'h40);
      step("put beat", 0);
    end
    d_rsp(3'd0, 3'd5, 4'd1);
    step("put ack", 0);
    check("put count", int'(inflight_count), 0);
    for (int b = 0; b < 4; b++) begin
      a_req(3'd0, 3'd0, 3'd5, (b == 2) ? 4'd2 : 4'd1, 32'h40);
      step("put2 beat", (b == 2) ? 5 : 0);
    end
    d_rsp(3'd0, 3'd5, 4'd1);
    step("put2 ack", 0);
    check("put2 first_err", int'(first_err), 5);
    check("put2 count", int'(inflight_count), 0);

    // A-channel address changes while stalled.
    do_reset("rst1");
    a_req(3'd4, 3'd0, 3'd2, 4'd4, 32'h200, 1'b0);
    step("a stall", 0);
    a_req(3'd4, 3'd0, 3'd2, 4'd4, 32'h204);
    step("a unstable", 4);
    check("a unstable first_err", int'(first_err), 4);
    d_rsp(3'd1, 3'd2, 4'd4);
    step("a unstable ack", 0);
    step("quiet", 0);

    // Response-side and request-side checks.
    do_reset("rst2");
    d_rsp(3'd0, 3'd0, 4'd9);
    step("d no req", 6);
    a_req(3'd4, 3'd0, 3'd3, 4'd3, 32'h100);
    step("get3 again", 0);
    a_req(3'd4, 3'd0, 3'd3, 4'd3, 32'h100);
    step("src busy", 3);
    d_rsp(3'd1, 3'd3, 4'd3);
    step("busy ack", 0);
    check("busy count", int'(inflight_count), 0);
    a_req(3'd4, 3'd0, 3'd3, 4'd5, 32'h104);
    step("misalign", 2);
    d_rsp(3'd1, 3'd3, 4'd5);
    step("misalign ack", 0);
    a_req(3'd4, 3'd0, 3'd2, 4'd7, 32'h0);
    step("get7", 0);
    d_rsp(3'd0, 3'd2, 4'd7);
    step("d opcode", 7);
    a_req(3'd4, 3'd0, 3'd2, 4'd8, 32'h0);
    step("get8", 0);
    d_rsp(3'd1, 3'd3, 4'd8);
    step("d size", 8);
    a_req(3'd4, 3'd0, 3'd0, 4'd10, 32'h1);
    step("get10", 0);
    d_rsp(3'd1, 3'd0, 4'd10, 1'b0);
    step("d stall", 0);
    d_rsp(3'd1, 3'd0, 4'd10, 1'b1, 1'b1);
    step("d unstable", 9);
    check("resp count", int'(inflight_count), 0);
    a_req(3'd6, 3'd0, 3'd0, 4'd6, 32'h0);
    step("a opcode", 1);
    check("resp first_err", int'(first_err), 6);

    // Same-cycle set and clear on source 2.
    do_reset("rst3");
    a_req(3'd4, 3'd0, 3'd3, 4'd2, 32'h0);
    step("get2", 0);
    check("get2 count", int'(inflight_count), 1);
    a_req(3'd4, 3'd0, 3'd3, 4'd2, 32'h0);
    d_rsp(3'd1, 3'd3, 4'd2);
    step("same cycle", 0);
    check("same cycle count", int'(inflight_count), 1);
    d_rsp(3'd1, 3'd3, 4'd2);
    step("same cycle ack", 0);
    check("same cycle final count", int'(inflight_count), 0);

    // Watchdog, then reset in the middle of a burst.
    do_reset("rst4");
    a_req(3'd4, 3'd0, 3'd3, 4'd1, 32'h0);
    step("wd get", 0);
    for (int k = 1; k <= 20; k++) step($sformatf("wd t%0d", k), (k == 16) ? 10 : 0);
    check("wd first_err", int'(first_err), 10);
    for (int b = 0; b < 2; b++) begin
      a_req(3'd0, 3'd0, 3'd5, 4'd3, 32'h0);
      step("burst pre rst", 0);
    end
    do_reset("rst mid");
    a_req(3'd4, 3'd0, 3'd3, 4'd3, 32'h0);
    step("post rst get", 0);
    check("post rst count", int'(inflight_count), 1);
    d_rsp(3'd1, 3'd3, 4'd3);
    step("post rst ack", 0);
    check("post rst final count", int'(inflight_count), 0);

    for (int k = 0; k < 4 && exp_q.size() != 0; k++) @(negedge clock);
    check("scoreboard drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
